// File: rtl/univ_shift_reg_if.sv
// Control and data bundle for the universal shift register.
// The master drives operation requests; the slave returns register state and burst status.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int AW = $clog2(WIDTH) + 1;

    logic             en;
    logic [2:0]       mode;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] par_in;
    logic             start;
    logic [AW-1:0]    amount;
    logic [WIDTH-1:0] q;
    logic             sout_msb;
    logic             sout_lsb;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, sin_l, sin_r, par_in, start, amount,
        input  q, sout_msb, sout_lsb, busy, done
    );

    modport slave (
        input  en, mode, sin_l, sin_r, par_in, start, amount,
        output q, sout_msb, sout_lsb, busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: single-step shift/rotate/load plus a
// counted burst engine that repeats one shift operation with a busy/done handshake.
module univ_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    univ_shift_reg_if.slave bus
);
    localparam int AW = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             burst_mode;

    function automatic logic [WIDTH-1:0] step_fn(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] v,
        input logic             sl,
        input logic             sr,
        input logic [WIDTH-1:0] par
    );
        logic [WIDTH-1:0] r;
        case (op)
            3'b001:  r = {v[WIDTH-2:0], sr};
            3'b010:  r = {sl, v[WIDTH-1:1]};
            3'b011:  r = {v[WIDTH-2:0], v[WIDTH-1]};
            3'b100:  r = {v[0], v[WIDTH-1:1]};
            3'b101:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            3'b110:  r = par;
            default: r = v;
        endcase
        return r;
    endfunction

    // Only the five shift/rotate modes can be repeated as a burst.
    assign burst_mode = (bus.mode >= 3'd1) && (bus.mode <= 3'd5);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && burst_mode) begin
                    op_d  = bus.mode;
                    cnt_d = bus.amount;
                    if (bus.amount != '0) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (bus.en) begin
                    q_d = step_fn(bus.mode, q_q, bus.sin_l, bus.sin_r, bus.par_in);
                end
            end
            RUN: begin
                if (bus.en) begin
                    q_d   = step_fn(op_q, q_q, bus.sin_l, bus.sin_r, bus.par_in);
                    cnt_d = cnt_q - AW'(1);
                    if (cnt_q == AW'(1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.q        = q_q;
    assign bus.sout_msb = q_q[WIDTH-1];
    assign bus.sout_lsb = q_q[0];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus randomized
// traffic, all compared against an arithmetic reference model.
module tb_univ_shift_reg;
    localparam int W    = 8;
    localparam int AW   = $clog2(W) + 1;
    localparam int HALF = 5;
    localparam longint MOD = longint'(1) << W;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    univ_shift_reg_if #(.WIDTH(W)) bus ();

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #HALF clk = ~clk;

    // Reference model state: register value as a plain number, burst as a remaining-step count.
    longint   m_q;
    bit       m_busy;
    bit       m_done;
    int       m_rem;
    bit [2:0] m_op;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic longint apply(input bit [2:0] op, input longint v,
                                     input bit sl, input bit sr, input longint par);
        case (op)
            3'd1:    return (v * 2 + sr) % MOD;
            3'd2:    return v / 2 + sl * (MOD / 2);
            3'd3:    return (v * 2) % MOD + v / (MOD / 2);
            3'd4:    return v / 2 + (v % 2) * (MOD / 2);
            3'd5:    return v / 2 + (v / (MOD / 2)) * (MOD / 2);
            3'd6:    return par;
            default: return v;
        endcase
    endfunction

    task automatic model_reset();
        m_q    = 0;
        m_busy = 0;
        m_done = 0;
        m_rem  = 0;
        m_op   = 0;
    endtask

    task automatic model_step();
        bit nd;
        nd = 0;
        if (!m_busy) begin
            if (bus.start && bus.mode >= 3'd1 && bus.mode <= 3'd5) begin
                m_op = bus.mode;
                if (bus.amount == 0) nd = 1;
                else begin
                    m_busy = 1;
                    m_rem  = int'(bus.amount);
                end
            end else if (bus.en) begin
                m_q = apply(bus.mode, m_q, bus.sin_l, bus.sin_r, longint'(bus.par_in));
            end
        end else if (bus.en) begin
            m_q = apply(m_op, m_q, bus.sin_l, bus.sin_r, longint'(bus.par_in));
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 0;
                nd     = 1;
            end
        end
        m_done = nd;
    endtask

    task automatic drive(input bit en, input bit [2:0] mode, input bit sl, input bit sr,
                         input logic [W-1:0] par, input bit st, input logic [AW-1:0] amt);
        bus.en     = en;
        bus.mode   = mode;
        bus.sin_l  = sl;
        bus.sin_r  = sr;
        bus.par_in = par;
        bus.start  = st;
        bus.amount = amt;
    endtask

    // One clock: update the model from the applied inputs, sample just after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("q",        32'(bus.q),        32'(m_q));
        chk("busy",     32'(bus.busy),     32'(m_busy));
        chk("done",     32'(bus.done),     32'(m_done));
        chk("sout_msb", 32'(bus.sout_msb), 32'(m_q / (MOD / 2)));
        chk("sout_lsb", 32'(bus.sout_lsb), 32'(m_q % 2));
        @(negedge clk);
    endtask

    task automatic load(input logic [W-1:0] v);
        drive(1, 3'd6, 0, 0, v, 0, '0);
        tick();
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        chk({tag, "_q"},    32'(bus.q),    32'h0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
        chk({tag, "_done"}, 32'(bus.done), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int nb;
        int nd;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        model_reset();
        drive(0, 3'd0, 0, 0, '0, 0, '0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_q",    32'(bus.q),    32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        rst = 1'b1;

        // Single steps
        load(8'hA5);                          chk("ld_a5", 32'(bus.q), 32'hA5);
        drive(1, 3'd1, 0, 1, '0, 0, '0); tick(); chk("shl",   32'(bus.q), 32'h4B);
        drive(1, 3'd2, 0, 0, '0, 0, '0); tick(); chk("shr",   32'(bus.q), 32'h25);
        drive(1, 3'd0, 1, 1, '0, 0, '0); tick(); chk("hold",  32'(bus.q), 32'h25);
        drive(0, 3'd1, 1, 1, '0, 0, '0); tick(); chk("en0",   32'(bus.q), 32'h25);
        load(8'h96); drive(1, 3'd5, 0, 0, '0, 0, '0); tick(); chk("asr", 32'(bus.q), 32'hCB);
        load(8'h81); drive(1, 3'd3, 0, 0, '0, 0, '0); tick(); chk("rol", 32'(bus.q), 32'h03);
        load(8'h01); drive(1, 3'd4, 0, 0, '0, 0, '0); tick(); chk("ror", 32'(bus.q), 32'h80);
        drive(1, 3'd7, 1, 1, '0, 0, '0); tick(); chk("rsvd", 32'(bus.q), 32'h80);

        // Asynchronous reset during single-step activity
        drive(1, 3'd1, 0, 1, '0, 0, '0);
        async_reset("arst");

        // Basic burst: rotate right by 3
        load(8'h01);
        nb = 0; nd = 0;
        drive(1, 3'd4, 0, 0, '0, 1, AW'(3)); tick(); nb += int'(bus.busy); nd += int'(bus.done);
        chk("b_start_q", 32'(bus.q), 32'h01);
        drive(1, 3'd0, 0, 0, '0, 0, '0);
        tick(); nb += int'(bus.busy); nd += int'(bus.done); chk("b_s1", 32'(bus.q), 32'h80);
        tick(); nb += int'(bus.busy); nd += int'(bus.done); chk("b_s2", 32'(bus.q), 32'h40);
        tick(); nb += int'(bus.busy); nd += int'(bus.done); chk("b_s3", 32'(bus.q), 32'h20);
        chk("b_done", 32'(bus.done), 32'h1);
        tick(); nb += int'(bus.busy); nd += int'(bus.done);
        chk("b_busy_cycles", 32'(nb), 32'd3);
        chk("b_done_cycles", 32'(nd), 32'd1);

        // Burst with a two-cycle stall and a start pulse that must be ignored
        load(8'h01);
        nb = 0;
        drive(1, 3'd4, 0, 0, '0, 1, AW'(3)); tick(); nb += int'(bus.busy);
        drive(1, 3'd0, 0, 0, '0, 0, '0);     tick(); nb += int'(bus.busy);
        drive(0, 3'd6, 0, 0, 8'hFF, 1, AW'(7)); tick(); nb += int'(bus.busy);
        drive(0, 3'd1, 1, 1, 8'hFF, 1, AW'(2)); tick(); nb += int'(bus.busy);
        drive(1, 3'd6, 1, 1, 8'hFF, 1, AW'(9)); tick(); nb += int'(bus.busy);
        drive(1, 3'd0, 0, 0, '0, 0, '0);     tick(); nb += int'(bus.busy);
        chk("stall_busy_cycles", 32'(nb), 32'd5);
        chk("stall_q", 32'(bus.q), 32'h20);

        // Zero-length burst, then a start accepted in the done cycle
        drive(1, 3'd1, 0, 1, '0, 1, AW'(0)); tick();
        chk("z_done", 32'(bus.done), 32'h1);
        chk("z_q",    32'(bus.q),    32'h20);
        drive(1, 3'd3, 0, 0, '0, 1, AW'(8)); tick();
        chk("z_restart_busy", 32'(bus.busy), 32'h1);
        drive(1, 3'd0, 0, 0, '0, 0, '0);
        for (int i = 0; i < 8; i++) tick();
        chk("rot_w_restores", 32'(bus.q), 32'h20);

        // Logical shift by more than WIDTH fills from the serial input
        drive(1, 3'd1, 0, 1, '0, 1, AW'(10)); tick();
        for (int i = 0; i < 10; i++) tick();
        chk("fill_ones", 32'(bus.q), 32'hFF);

        // Reset after 2 of 5 steps, then a fresh burst
        load(8'h01);
        drive(1, 3'd4, 0, 0, '0, 1, AW'(5)); tick();
        drive(1, 3'd0, 0, 0, '0, 0, '0); tick(); tick();
        chk("mid_q", 32'(bus.q), 32'h40);
        async_reset("mrst");
        tick(); tick();
        chk("mrst_nodone", 32'(bus.done), 32'h0);
        load(8'h81);
        drive(1, 3'd5, 0, 0, '0, 1, AW'(2)); tick();
        drive(1, 3'd0, 0, 0, '0, 0, '0); tick(); tick();
        chk("fresh_q",    32'(bus.q),    32'hE0);
        chk("fresh_done", 32'(bus.done), 32'h1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)), 1'($urandom),
                  1'($urandom), W'($urandom), $urandom_range(0, 3) == 0,
                  AW'($urandom_range(0, (1 << AW) - 1)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
